// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared types and constants for the serial parity checker
package serial_parity_checker_pkg;

  // Frame reception phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_PARITY_ODD = 0;

  // Parity sense: the value XORed into the check so that a correct frame yields 0
  localparam logic SENSE_EVEN = 1'b0;
  localparam logic SENSE_ODD  = 1'b1;

  function automatic logic parity_mismatch(input logic acc, input logic pbit, input logic sense);
    return acc ^ pbit ^ sense;
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// rtl/serial_parity_checker_parity_acc.sv - registered XOR parity accumulator
module serial_parity_checker_parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic acc_en,
  input  logic bit_in,
  output logic acc
);

  // Clear wins over load, load wins over accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= bit_in;
    end else if (acc_en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - deserialises LSB-first frames and checks their parity bit
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              sof,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int              CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_W - 1);
  localparam logic            SENSE    = (PARITY_ODD != 0) ? SENSE_ODD : SENSE_EVEN;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [CW-1:0]     cnt;
  logic              acc;

  // sof with bit_valid always restarts a frame, whatever state we are in
  logic start;
  logic take;
  logic acc_en;
  logic parity_take;
  logic err;

  assign start       = bit_valid & sof;
  assign take        = bit_valid & ~sof;
  assign acc_en      = take & (state == DATA);
  assign parity_take = take & (state == PARITY);
  assign err         = parity_mismatch(acc, bit_in, SENSE);

  serial_parity_checker_parity_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (parity_take),
    .load   (start),
    .acc_en (acc_en),
    .bit_in (bit_in),
    .acc    (acc)
  );

  // Frame FSM with registered outputs and the saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      err_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (start) begin
        // Bits enter at the MSB and shift down, so after DATA_W bits the first lands at bit 0
        word  <= {bit_in, {(DATA_W-1){1'b0}}};
        cnt   <= CW'(1);
        state <= DATA;
        busy  <= 1'b1;
      end else if (take) begin
        unique case (state)
          DATA: begin
            word <= {bit_in, word[DATA_W-1:1]};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST_IDX) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            data_out   <= word;
            parity_err <= err;
            data_valid <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end

      if (err_clr) begin
        err_cnt <= '0;
      end else if (parity_take && err && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - scoreboard bench for serial_parity_checker (even and odd builds)
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst;
  logic bit_valid;
  logic bit_in;
  logic sof;
  logic err_clr;

  logic [7:0] data_out_e, data_out_o;
  logic       data_valid_e, data_valid_o;
  logic       parity_err_e, parity_err_o;
  logic [7:0] err_cnt_e, err_cnt_o;
  logic       busy_e, busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic [7:0] c;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  int   m_cnt_e = 0;
  int   m_cnt_o = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(8)) dut_e (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof), .err_clr(err_clr),
    .data_out(data_out_e), .data_valid(data_valid_e), .parity_err(parity_err_e),
    .err_cnt(err_cnt_e), .busy(busy_e)
  );

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(8)) dut_o (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof), .err_clr(err_clr),
    .data_out(data_out_o), .data_valid(data_valid_o), .parity_err(parity_err_o),
    .err_cnt(err_cnt_o), .busy(busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected response model, pushed just before the parity bit is sampled
  task automatic push_exp(input logic [7:0] d, input logic p, input logic clr);
    exp_t x;
    logic pe_even;
    logic pe_odd;
    pe_even = (^d) ^ p;
    pe_odd  = ~pe_even;
    if (clr) m_cnt_e = 0;
    else if (pe_even && m_cnt_e < 255) m_cnt_e++;
    if (clr) m_cnt_o = 0;
    else if (pe_odd && m_cnt_o < 255) m_cnt_o++;
    x.d = d; x.pe = pe_even; x.c = 8'(m_cnt_e);
    q_e.push_back(x);
    x.pe = pe_odd; x.c = 8'(m_cnt_o);
    q_o.push_back(x);
  endtask

  task automatic cyc(input logic v, input logic b, input logic s, input logic c);
    bit_valid = v; bit_in = b; sof = s; err_clr = c;
    @(posedge clk);
    #1;
    bit_valid = 1'b0; sof = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, d[i], i == 0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gaps,
                            input logic clr, input bit chk_busy);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps; g++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        if (chk_busy && i > 0) chk("busy_gap", busy_e, 1);
      end
      cyc(1'b1, d[i], i == 0, 1'b0);
      if (chk_busy) chk("busy_data", busy_e, 1);
    end
    for (int g = 0; g < gaps; g++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (chk_busy) chk("busy_pgap", busy_e, 1);
    end
    push_exp(d, p, clr);
    cyc(1'b1, p, 1'b0, clr);
    if (chk_busy) chk("busy_after_parity", busy_e, 0);
  endtask

  // Even-build monitor
  always @(negedge clk) begin
    if (!rst && data_valid_e) begin
      if (q_e.size() == 0) begin
        chk("even_unexpected_valid", 1, 0);
      end else begin
        exp_t x;
        x = q_e.pop_front();
        chk("even_data_out", data_out_e, x.d);
        chk("even_parity_err", parity_err_e, x.pe);
        chk("even_err_cnt", err_cnt_e, x.c);
      end
    end
  end

  // Odd-build monitor
  always @(negedge clk) begin
    if (!rst && data_valid_o) begin
      if (q_o.size() == 0) begin
        chk("odd_unexpected_valid", 1, 0);
      end else begin
        exp_t x;
        x = q_o.pop_front();
        chk("odd_data_out", data_out_o, x.d);
        chk("odd_parity_err", parity_err_o, x.pe);
        chk("odd_err_cnt", err_cnt_o, x.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out_e, 0);
    chk("rst_data_valid", data_valid_e, 0);
    chk("rst_parity_err", parity_err_e, 0);
    chk("rst_err_cnt", err_cnt_e, 0);
    chk("rst_busy", busy_e, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Stray bits without sof are ignored in IDLE
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_no_sof_busy", busy_e, 0);

    // 0xA5 with correct even parity, then held outputs
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_data_out", data_out_e, 8'hA5);
    chk("hold_data_valid", data_valid_e, 0);

    // Bad even parity
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);

    // Same good frame with 3-cycle gaps between every bit
    send_frame(8'hA5, 1'b0, 3, 1'b0, 1'b1);

    // Abort from DATA after 4 bits, then a good 0x3C
    send_bits(8'h0F, 4);
    send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);

    // Abort from PARITY (all data bits in, sof instead of parity)
    send_bits(8'hFF, 8);
    send_frame(8'h5A, 1'b0, 1, 1'b0, 1'b0);

    // Reset mid-frame after 5 bits
    send_bits(8'h1F, 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_e, 0);
    chk("midrst_data_out", data_out_e, 0);
    chk("midrst_err_cnt", err_cnt_e, 0);
    m_cnt_e = 0;
    m_cnt_o = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 0, 1'b0, 1'b0);

    // Saturation at 255, then clear colliding with another error
    for (int n = 0; n < 260; n++) send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    chk("sat_err_cnt", err_cnt_e, 255);
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    chk("clr_priority_err_cnt", err_cnt_e, 0);

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("even_queue_drained", q_e.size(), 0);
    chk("odd_queue_drained", q_o.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Receive-side counterpart of the team's XOR parity generation path. It deserialises a bit stream framed as DATA_W data bits (LSB first) followed by one parity bit. It accumulates XOR parity on the fly and presents the recovered word with a parity-error flag. It sits between the serial link front end and the byte-level consumer, and keeps a saturating error count for status readout.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected
CNT_W, 8, width of parity error counter

Ports:
clk  input  1  single clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
bit_valid  input  1  qualifies bit_in and sof this cycle
bit_in  input  1  serial data/parity bit
sof  input  1  start of frame; marks bit_in as data bit 0; ignored unless bit_valid=1
err_clr  input  1  synchronous clear of err_cnt
data_out  output  DATA_W  last completed frame's data word
data_valid  output  1  one-cycle pulse, frame complete
parity_err  output  1  parity result of last completed frame (1 = mismatch)
err_cnt  output  CNT_W  saturating count of frames with parity_err=1
busy  output  1  high while in DATA or PARITY state

Behaviour:
- Reset (async assert, sync-clean deassert): state=IDLE, data_out=0, data_valid=0, parity_err=0, err_cnt=0, busy=0, bit counter=0, accumulator=0.
- FSM states: IDLE, DATA, PARITY.
- IDLE: bit_valid & sof -> shift bit_in into shift-register bit 0, acc=bit_in, cnt=1, go DATA (PARITY if DATA_W... n/a, DATA_W>=2). bit_valid without sof is discarded.
- DATA: each bit_valid & !sof -> store bit_in at position cnt (LSB first), acc ^= bit_in, cnt++; when cnt reaches DATA_W after the store -> PARITY. bit_valid=0 cycles are gaps: no state change, unlimited length.
- PARITY: bit_valid & !sof -> err = acc ^ bit_in ^ PARITY_ODD. Next cycle: data_out=word, parity_err=err, data_valid=1. Return to IDLE.
- Latency: data_valid asserts exactly 1 cycle after the cycle sampling the parity bit.
- sof with bit_valid in DATA or PARITY: abort the current frame, with no data_valid and no count. The bit is treated as data bit 0 of a new frame (same action as from IDLE).
- data_out and parity_err hold until the next completed frame; data_valid is low otherwise.
- err_cnt: +1 on each completed frame with err=1 (same cycle as data_valid); saturates at 2^CNT_W-1. err_clr has priority over a simultaneous increment (result 0).
- busy = (state != IDLE).
- Reset asserted mid-frame: partial frame discarded, no data_valid pulse after release.

Decomposition:
- Shared package: FSM state enum (IDLE/DATA/PARITY), default DATA_W and PARITY_ODD constants, parity sense encoding.
- One natural sub-module, parity_acc: registered XOR accumulator with load/accumulate/clear controls, reusable by the transmit-side generator.

Test Plan:
- Even parity, sof+bits 1,0,1,0,0,1,0,1 then parity 0, no gaps -> one cycle later data_out=0xA5, data_valid=1 for one cycle, parity_err=0, err_cnt=0.
- Same frame with parity bit 1 -> data_out=0xA5, parity_err=1, err_cnt=1; repeat with PARITY_ODD=1 build and parity 1 -> parity_err=0.
- Same frame with bit_valid low for 3 cycles between every bit -> identical result to the no-gap case; busy high from first bit until the parity bit is consumed.
- Abort: sof, 4 data bits, then sof+0x3C frame with correct parity -> single data_valid, data_out=0x3C, err_cnt unchanged.
- Saturation/clear: CNT_W=8, 260 bad-parity frames -> err_cnt=255; err_clr in the same cycle as a 261st error -> err_cnt=0.
- Reset mid-frame after 5 bits, release, then send a full 0x81 frame -> no output from the partial frame; data_out=0x81 with one data_valid pulse.
